// File: rtl/apb_master_fsm_if.sv
// apb_master_fsm_if: request/response and APB bus bundle for the APB transfer controller
// Parameters match the controller: RATIO slaves, logRATIO index width, ADDR_W/DATA_W bus widths.
// master modport: controller side (drives o_*, reads i_*).
// slave modport : requester/slave side (drives i_*, reads o_*).
// Signals: i_req_valid/o_req_ready/i_req_addr/i_req_write/i_req_wdata (request),
//          o_rsp_valid/o_rsp_rdata/o_rsp_err (response), o_sel_idx (slave index),
//          o_psel/o_penable/o_paddr/o_pwrite/o_pwdata (APB out),
//          i_pready/i_pslverr/i_prdata (per-slave APB in, slave k at [k*DATA_W +: DATA_W]).
interface apb_master_fsm_if #(
  parameter int RATIO = 4,
  parameter int logRATIO = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic [ADDR_W-1:0]       i_req_addr;
  logic                    i_req_write;
  logic [DATA_W-1:0]       i_req_wdata;
  logic                    o_rsp_valid;
  logic [DATA_W-1:0]       o_rsp_rdata;
  logic                    o_rsp_err;
  logic [logRATIO-1:0]     o_sel_idx;
  logic [RATIO-1:0]        o_psel;
  logic                    o_penable;
  logic [ADDR_W-1:0]       o_paddr;
  logic                    o_pwrite;
  logic [DATA_W-1:0]       o_pwdata;
  logic [RATIO-1:0]        i_pready;
  logic [RATIO-1:0]        i_pslverr;
  logic [RATIO*DATA_W-1:0] i_prdata;
  modport master (
    input  i_req_valid, i_req_addr, i_req_write, i_req_wdata, i_pready, i_pslverr, i_prdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_sel_idx,
           o_psel, o_penable, o_paddr, o_pwrite, o_pwdata
  );
  modport slave (
    output i_req_valid, i_req_addr, i_req_write, i_req_wdata, i_pready, i_pslverr, i_prdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_sel_idx,
           o_psel, o_penable, o_paddr, o_pwrite, o_pwdata
  );
endinterface

// File: rtl/apb_master_fsm.sv
// apb_master_fsm: APB SETUP/ACCESS transfer controller with slave select and wait-state timeout
// Ports: i_clk (rising-edge clock), i_rst_n (synchronous active-low reset),
//        bus (apb_master_fsm_if.master: request handshake, one-cycle response, APB bus).
// o_sel_idx is the registered slave index that steers PSEL and the PREADY/PRDATA mux.
module apb_master_fsm #(
  parameter int RATIO = 4,
  parameter int logRATIO = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 16
) (
  input logic i_clk,
  input logic i_rst_n,
  apb_master_fsm_if.master bus
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic hs, rdy, tmo, done;
  logic [DATA_W-1:0] rdata_sel;
  always_ff @(posedge i_clk) state <= !i_rst_n ? IDLE : nxt;
  // Only the selected slave's PREADY/PRDATA matter; PREADY wins over a coincident timeout.
  always_comb begin
    hs = state == IDLE && bus.i_req_valid;
    rdy = bus.i_pready[bus.o_sel_idx];
    tmo = TIMEOUT != 0 && cnt == TLAST;
    done = state == ACCESS && (rdy || tmo);
    rdata_sel = bus.i_prdata[int'(bus.o_sel_idx)*DATA_W +: DATA_W];
    nxt = state == IDLE ? (hs ? SETUP : IDLE) : state == SETUP ? ACCESS : done ? IDLE : ACCESS;
  end
  always_comb begin
    bus.o_req_ready = state == IDLE;
    bus.o_psel = state == IDLE ? '0 : RATIO'(1) << bus.o_sel_idx;
    bus.o_penable = state == ACCESS;
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      bus.o_paddr <= '0;
      bus.o_pwrite <= 1'b0;
      bus.o_pwdata <= '0;
      bus.o_sel_idx <= '0;
      bus.o_rsp_valid <= 1'b0;
      bus.o_rsp_rdata <= '0;
      bus.o_rsp_err <= 1'b0;
      cnt <= '0;
    end else begin
      bus.o_rsp_valid <= done;
      if (hs) begin
        bus.o_paddr <= bus.i_req_addr;
        bus.o_pwrite <= bus.i_req_write;
        bus.o_pwdata <= bus.i_req_wdata;
        bus.o_sel_idx <= bus.i_req_addr[SEL_LSB +: logRATIO];
        cnt <= '0;
      end
      if (state == ACCESS && !rdy) cnt <= cnt + 1'b1;
      if (done) begin
        bus.o_rsp_rdata <= rdy && !bus.o_pwrite ? rdata_sel : '0;
        bus.o_rsp_err <= rdy ? bus.i_pslverr[bus.o_sel_idx] : 1'b1;
      end
    end
endmodule

// File: tb/tb_apb_master_fsm.sv
// tb_apb_master_fsm: directed stimulus with a response scoreboard for apb_master_fsm
module tb_apb_master_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  apb_master_fsm_if #(.RATIO(4), .logRATIO(2), .ADDR_W(32), .DATA_W(32)) bus();
  apb_master_fsm #(
    .RATIO(4), .logRATIO(2), .ADDR_W(32), .DATA_W(32), .SEL_LSB(28), .TIMEOUT(16)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic setpr(input int k, input logic [31:0] v);
    bus.i_prdata[k*32 +: 32] = v;
  endtask
  task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [31:0] er, input logic ee, input int lat);
    bus.i_req_valid = 1'b1;
    bus.i_req_addr = a;
    bus.i_req_write = w;
    bus.i_req_wdata = d;
    chk("req_ready", bus.o_req_ready, 1);
    sb.push_back('{er, ee, cyc + lat});
  endtask
  initial forever begin
    @(negedge clk);
    if (bus.o_rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got a response at cycle %0d, required none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", bus.o_rsp_rdata, e.rdata);
        chk("rsp_err", bus.o_rsp_err, e.err);
        chk("rsp_cycle", cyc, e.at);
      end
    end
  end
  initial begin
    #50000;
    $display("FAIL watchdog: run did not complete, required completion");
    $fatal(1);
  end
  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_addr = '0;
    bus.i_req_write = 1'b0;
    bus.i_req_wdata = '0;
    bus.i_pready = '0;
    bus.i_pslverr = '0;
    bus.i_prdata = '0;
    step();
    step();
    chk("rst_psel", bus.o_psel, 0);
    chk("rst_penable", bus.o_penable, 0);
    chk("rst_rsp_valid", bus.o_rsp_valid, 0);
    chk("rst_rsp_rdata", bus.o_rsp_rdata, 0);
    chk("rst_rsp_err", bus.o_rsp_err, 0);
    chk("rst_paddr", bus.o_paddr, 0);
    chk("rst_pwrite", bus.o_pwrite, 0);
    chk("rst_pwdata", bus.o_pwdata, 0);
    chk("rst_sel_idx", bus.o_sel_idx, 0);
    chk("rst_req_ready", bus.o_req_ready, 1);
    rst_n = 1'b1;
    step();
    // zero-wait read from slave 2
    bus.i_pready = 4'b0100;
    setpr(2, 32'hDEAD_BEEF);
    req(32'h2000_0010, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
    step();
    bus.i_req_valid = 1'b0;
    chk("t1_setup_psel", bus.o_psel, 4'b0100);
    chk("t1_setup_penable", bus.o_penable, 0);
    chk("t1_sel_idx", bus.o_sel_idx, 2);
    chk("t1_paddr", bus.o_paddr, 32'h2000_0010);
    chk("t1_pwrite", bus.o_pwrite, 0);
    step();
    chk("t1_access_psel", bus.o_psel, 4'b0100);
    chk("t1_access_penable", bus.o_penable, 1);
    step();
    chk("t1_idle_psel", bus.o_psel, 0);
    chk("t1_idle_penable", bus.o_penable, 0);
    chk("t1_idle_ready", bus.o_req_ready, 1);
    step();
    // write to slave 1, ready on the 4th ACCESS cycle
    bus.i_pready = 4'b0000;
    setpr(1, 32'hFFFF_FFFF);
    req(32'h1000_0004, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 6);
    step();
    bus.i_req_valid = 1'b0;
    chk("t2_setup_psel", bus.o_psel, 4'b0010);
    chk("t2_setup_penable", bus.o_penable, 0);
    chk("t2_pwrite", bus.o_pwrite, 1);
    chk("t2_pwdata", bus.o_pwdata, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) bus.i_pready = 4'b0010;
      chk("t2_access_psel", bus.o_psel, 4'b0010);
      chk("t2_access_penable", bus.o_penable, 1);
      chk("t2_access_paddr", bus.o_paddr, 32'h1000_0004);
      chk("t2_access_pwdata", bus.o_pwdata, 32'h1234_5678);
    end
    step();
    bus.i_pready = 4'b0000;
    chk("t2_idle_psel", bus.o_psel, 0);
    // slave 3 error while other slaves shout ready+error
    bus.i_pready = 4'b0111;
    bus.i_pslverr = 4'b0111;
    setpr(0, 32'h1111_0000);
    setpr(1, 32'h2222_0001);
    setpr(2, 32'h4444_0002);
    setpr(3, 32'h3333_0003);
    req(32'h3000_0000, 1'b0, 32'h0, 32'h3333_0003, 1'b1, 4);
    step();
    bus.i_req_valid = 1'b0;
    chk("t3_setup_psel", bus.o_psel, 4'b1000);
    step();
    chk("t3_wait_penable", bus.o_penable, 1);
    chk("t3_wait_psel", bus.o_psel, 4'b1000);
    step();
    bus.i_pready = 4'b1111;
    bus.i_pslverr = 4'b1111;
    chk("t3_access_penable", bus.o_penable, 1);
    step();
    chk("t3_idle_psel", bus.o_psel, 0);
    bus.i_pready = 4'b0000;
    bus.i_pslverr = 4'b0000;
    // timeout on slave 0
    setpr(0, 32'hAAAA_AAAA);
    req(32'h0000_0100, 1'b0, 32'h0, 32'h0, 1'b1, 18);
    step();
    bus.i_req_valid = 1'b0;
    chk("t4_setup_psel", bus.o_psel, 4'b0001);
    chk("t4_setup_penable", bus.o_penable, 0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("t4_access_penable", bus.o_penable, 1);
      chk("t4_access_psel", bus.o_psel, 4'b0001);
    end
    step();
    chk("t4_idle_psel", bus.o_psel, 0);
    chk("t4_idle_penable", bus.o_penable, 0);
    chk("t4_idle_ready", bus.o_req_ready, 1);
    // back-to-back with valid held high
    bus.i_pready = 4'b1111;
    setpr(0, 32'h0000_1111);
    setpr(1, 32'h0000_2222);
    req(32'h0000_0000, 1'b0, 32'h0, 32'h0000_1111, 1'b0, 3);
    step();
    bus.i_req_addr = 32'h1000_0008;
    chk("t5_first_setup_psel", bus.o_psel, 4'b0001);
    step();
    chk("t5_first_access_psel", bus.o_psel, 4'b0001);
    chk("t5_first_access_penable", bus.o_penable, 1);
    step();
    chk("t5_gap_psel", bus.o_psel, 0);
    req(32'h1000_0008, 1'b0, 32'h0, 32'h0000_2222, 1'b0, 3);
    step();
    bus.i_req_valid = 1'b0;
    chk("t5_second_setup_psel", bus.o_psel, 4'b0010);
    chk("t5_second_sel_idx", bus.o_sel_idx, 1);
    chk("t5_second_setup_penable", bus.o_penable, 0);
    step();
    chk("t5_second_access_psel", bus.o_psel, 4'b0010);
    chk("t5_second_access_penable", bus.o_penable, 1);
    step();
    chk("t5_idle_psel", bus.o_psel, 0);
    // reset during an ACCESS wait state, then a clean transfer
    bus.i_pready = 4'b0000;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr = 32'h2000_0000;
    bus.i_req_write = 1'b0;
    step();
    bus.i_req_valid = 1'b0;
    step();
    chk("t6_wait_penable", bus.o_penable, 1);
    step();
    rst_n = 1'b0;
    step();
    chk("t6_rst_psel", bus.o_psel, 0);
    chk("t6_rst_penable", bus.o_penable, 0);
    chk("t6_rst_rsp_valid", bus.o_rsp_valid, 0);
    chk("t6_rst_ready", bus.o_req_ready, 1);
    rst_n = 1'b1;
    step();
    chk("t6_after_rsp_valid", bus.o_rsp_valid, 0);
    bus.i_pready = 4'b0100;
    setpr(2, 32'h5555_0002);
    req(32'h2000_0000, 1'b0, 32'h0, 32'h5555_0002, 1'b0, 3);
    step();
    bus.i_req_valid = 1'b0;
    chk("t6_new_setup_psel", bus.o_psel, 4'b0100);
    step();
    chk("t6_new_access_penable", bus.o_penable, 1);
    step();
    step();
    step();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
